// File: rtl/any1_pkg.sv
// Shared opcode constants and the resolved-branch record for the branch resolve stage.
package any1_pkg;

    localparam int PC_W = 32;

    localparam logic [7:0] BEQ  = 8'h26;
    localparam logic [7:0] BNE  = 8'h27;
    localparam logic [7:0] BLT  = 8'h28;
    localparam logic [7:0] BGE  = 8'h29;
    localparam logic [7:0] BLTU = 8'h2A;
    localparam logic [7:0] BGEU = 8'h2B;

    typedef struct packed {
        logic            taken;
        logic            mispred;
        logic [PC_W-1:0] pc;
        logic [PC_W-1:0] redirect_pc;
    } br_res_t;

endpackage

// File: rtl/any1_eval_branch.sv
// Branch condition evaluator: purely combinational compare selected by inst[7:0].
// Unknown opcodes evaluate as not taken.
module any1_eval_branch
    import any1_pkg::*;
#(
    parameter int WID = 64
) (
    input  logic [63:0]    inst,
    input  logic [WID-1:0] a,
    input  logic [WID-1:0] b,
    output logic           takb
);

    // Only the opcode byte steers the compare.
    logic unused_inst_hi;
    assign unused_inst_hi = ^inst[63:8];

    always_comb begin
        takb = 1'b0;
        case (inst[7:0])
            BEQ:     takb = (a == b);
            BNE:     takb = (a != b);
            BLT:     takb = ($signed(a) <  $signed(b));
            BGE:     takb = ($signed(a) >= $signed(b));
            BLTU:    takb = (a <  b);
            BGEU:    takb = (a >= b);
            default: takb = 1'b0;
        endcase
    end

endmodule

// File: rtl/any1_branch_resolve.sv
// Branch resolve stage: one-entry result register, epoch-based squash, one-cycle redirect.
// Latency 1 cycle; in_ready_o = !full || out_ready_i, output held while stalled.
module any1_branch_resolve
    import any1_pkg::*;
#(
    parameter int WID    = 64,
    parameter int AWID   = 32,
    parameter int FT_INC = 8,
    parameter int CNTW   = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [63:0]     inst_i,
    input  logic            is_branch_i,
    input  logic [AWID-1:0] pc_i,
    input  logic [AWID-1:0] tgt_i,
    input  logic [WID-1:0]  a_i,
    input  logic [WID-1:0]  b_i,
    input  logic            pred_taken_i,
    input  logic [AWID-1:0] pred_tgt_i,
    input  logic            epoch_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic            out_taken_o,
    output logic            out_mispred_o,
    output logic [AWID-1:0] out_pc_o,
    output logic            redirect_o,
    output logic [AWID-1:0] redirect_pc_o,
    output logic            epoch_o,
    output logic [CNTW-1:0] br_cnt_o,
    output logic [CNTW-1:0] mp_cnt_o
);

    logic            takb;
    logic            full_q;
    logic            redirect_q;
    logic            epoch_q;
    br_res_t         res_d;
    br_res_t         res_q;
    logic [CNTW-1:0] br_cnt_q;
    logic [CNTW-1:0] mp_cnt_q;
    logic            accept;
    logic            load;

    any1_eval_branch #(.WID(WID)) u_eval (
        .inst (inst_i),
        .a    (a_i),
        .b    (b_i),
        .takb (takb)
    );

    assign in_ready_o = !full_q || out_ready_i;
    assign accept     = in_valid_i && in_ready_o;
    // Ops fetched before the last redirect carry the old epoch and are swallowed.
    assign load       = accept && (epoch_i == epoch_q);

    always_comb begin
        res_d             = '0;
        res_d.taken       = is_branch_i && takb;
        res_d.mispred     = is_branch_i && ((res_d.taken != pred_taken_i) ||
                                            (res_d.taken && (pred_tgt_i != tgt_i)));
        res_d.pc          = pc_i;
        res_d.redirect_pc = res_d.taken ? tgt_i : pc_i + AWID'(FT_INC);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            full_q     <= 1'b0;
            res_q      <= '0;
            redirect_q <= 1'b0;
            epoch_q    <= 1'b0;
            br_cnt_q   <= '0;
            mp_cnt_q   <= '0;
        end else begin
            if (load) begin
                full_q <= 1'b1;
                res_q  <= res_d;
            end else if (out_ready_i) begin
                full_q <= 1'b0;
            end
            redirect_q <= load && res_d.mispred;
            if (load && res_d.mispred) begin
                epoch_q <= ~epoch_q;
            end
            if (load && is_branch_i && (br_cnt_q != '1)) begin
                br_cnt_q <= br_cnt_q + CNTW'(1);
            end
            if (load && res_d.mispred && (mp_cnt_q != '1)) begin
                mp_cnt_q <= mp_cnt_q + CNTW'(1);
            end
        end
    end

    assign out_valid_o   = full_q;
    assign out_taken_o   = res_q.taken;
    assign out_mispred_o = res_q.mispred;
    assign out_pc_o      = res_q.pc;
    assign redirect_o    = redirect_q;
    assign redirect_pc_o = res_q.redirect_pc;
    assign epoch_o       = epoch_q;
    assign br_cnt_o      = br_cnt_q;
    assign mp_cnt_o      = mp_cnt_q;

endmodule
